cacheline_adaptor: RTL

//  Bridges the cache data path (full lines, byte write mask) and main memory (fixed 4-beat bursts).

---
 rtl/cacheline_adaptor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges full cache lines with byte masks and fixed multi-beat memory bursts.
// Latency: request -> resp_o is 1 + NUM_BEATS + 1 cycles minimum; memory may insert gaps between beats.
// Backpressure: resp_i paces each beat; new requests are sampled only in IDLE.
// Build option CACHELINE_ADAPTOR_BEAT_WRITE_EN: each fill beat is written through to the data array as it arrives.
module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64,
  localparam int LINE       = 8 * (2 ** s_offset),
  localparam int NUM_BEATS  = LINE / s_beat,
  localparam int CNT_W      = $clog2(NUM_BEATS),
  localparam int MASK_W     = LINE / 8,
  localparam int BEAT_BYTES = s_beat / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [31:0]       address_i,
  input  logic [LINE-1:0]   line_i,
  output logic [LINE-1:0]   line_o,
  output logic [MASK_W-1:0] mask_o,
  output logic              resp_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [s_beat-1:0] burst_o,
  input  logic [s_beat-1:0] burst_i,
  input  logic              resp_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINE-1:0]   r_line;
  logic [31:0]       r_addr;
  logic              r_wb;
  logic              w_last_beat;
  logic              w_read;
  logic              w_write;
  logic              w_resp;
  logic [MASK_W-1:0] w_mask;
  logic [LINE-1:0]   w_line;
  logic              w_unused;

  // Offset bits are dropped: memory always sees a line-aligned address.
  assign w_last_beat = resp_i && (r_cnt == CNT_W'(NUM_BEATS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and state-decoded memory/cache handshakes; writeback has priority over fill.
  always_comb begin
    w_next  = r_state;
    w_read  = 1'b0;
    w_write = 1'b0;
    w_resp  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (write_i)     w_next = S_WB;
        else if (read_i) w_next = S_FILL;
      end
      S_FILL: begin
        w_read = 1'b1;
        if (w_last_beat) w_next = S_DONE;
      end
      S_WB: begin
        w_write = 1'b1;
        if (w_last_beat) w_next = S_DONE;
      end
      S_DONE: begin
        w_resp = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Beat counter, line assembly and request latching; reset discards any partial fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_line <= '0;
      r_addr <= '0;
      r_wb   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (write_i || read_i) begin
            r_addr <= {address_i[31:s_offset], {s_offset{1'b0}}};
            r_wb   <= write_i;
          end
        end
        S_FILL: begin
          if (resp_i) begin
            r_line[r_cnt*s_beat +: s_beat] <= burst_i;
            r_cnt                          <= r_cnt + 1'b1;
          end
        end
        S_WB: begin
          if (resp_i) r_cnt <= r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_BEAT_WRITE_EN
  // Write-through fill: the arriving beat bypasses into its slot with only that slot's bytes enabled.
  always_comb begin
    w_mask = '0;
    w_line = r_line;
    if (r_state == S_FILL && resp_i) begin
      w_mask[r_cnt*BEAT_BYTES +: BEAT_BYTES] = '1;
      w_line[r_cnt*s_beat +: s_beat]         = burst_i;
    end
  end
  assign w_unused = ^{address_i[s_offset-1:0], r_wb};
`else
  // Whole-line fill: the assembled line is written in one shot when the fill completes.
  always_comb begin
    w_mask = '0;
    w_line = r_line;
    if (r_state == S_DONE && !r_wb) w_mask = '1;
  end
  assign w_unused = ^address_i[s_offset-1:0];
`endif

  assign read_o    = w_read;
  assign write_o   = w_write;
  assign resp_o    = w_resp;
  assign address_o = r_addr;
  assign line_o    = w_line;
  assign mask_o    = w_mask;
  assign burst_o   = (r_state == S_WB) ? line_i[r_cnt*s_beat +: s_beat] : '0;

endmodule
